// File: rtl/usb2_ep_in_writer.sv
// Packetizer feeding the IN side of a double-buffered USB 2.0 endpoint: bytes are
// written into the current buffer, then committed with a commit/ack level handshake.
module usb2_ep_in_writer #(
  parameter int MAX_PKT = 512,
  parameter bit ZLP_EN  = 1'b1
) (
  input  logic       phy_clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [8:0] buf_in_addr,
  output logic [7:0] buf_in_data,
  output logic       buf_in_wren,
  input  logic       buf_in_ready,
  output logic       buf_in_commit,
  output logic [9:0] buf_in_commit_len,
  input  logic       buf_in_commit_ack,
  output logic       pkt_done,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_GAP     = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [9:0] MAX_LEN = 10'(MAX_PKT);

  state_t     state_q, state_d;
  logic [9:0] cnt_q;
  logic [9:0] cnt_inc;
  logic       zlp_pend_q;
  logic       accept;
  logic       pkt_end;
  logic       zlp_hit;

  // Stream handshake: a byte transfers on every phy_clk edge where s_valid and
  // s_ready are both high; s_ready depends only on state, never on s_valid, and
  // the source must hold s_data/s_last stable until the transfer happens.
  assign accept  = s_valid & s_ready;
  assign cnt_inc = cnt_q + 10'd1;
  assign pkt_end = (cnt_inc == MAX_LEN) || s_last;
  assign zlp_hit = ZLP_EN && s_last && (cnt_inc == MAX_LEN);

  assign dbg_state = state_q;

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (buf_in_ready) begin
          state_d = zlp_pend_q ? ST_GAP : ST_FILL;
        end
      end
      ST_FILL: begin
        if (accept && pkt_end) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (buf_in_commit_ack) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Waiting for ack low guarantees the endpoint sees a low gap between commits.
        if (!buf_in_commit_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    s_ready       = 1'b0;
    buf_in_commit = 1'b0;
    busy          = 1'b1;
    case (state_q)
      ST_IDLE:   busy          = 1'b0;
      ST_FILL:   s_ready       = 1'b1;
      ST_COMMIT: buf_in_commit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge phy_clk) begin
    if (reset) begin
      cnt_q             <= 10'd0;
      zlp_pend_q        <= 1'b0;
      buf_in_addr       <= 9'd0;
      buf_in_data       <= 8'd0;
      buf_in_wren       <= 1'b0;
      buf_in_commit_len <= 10'd0;
      pkt_done          <= 1'b0;
    end else begin
      buf_in_wren <= 1'b0;
      pkt_done    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (buf_in_ready) begin
            if (zlp_pend_q) begin
              buf_in_commit_len <= 10'd0;
              zlp_pend_q        <= 1'b0;
            end else begin
              cnt_q <= 10'd0;
            end
          end
        end
        ST_FILL: begin
          if (accept) begin
            buf_in_addr <= cnt_q[8:0];
            buf_in_data <= s_data;
            buf_in_wren <= 1'b1;
            cnt_q       <= cnt_inc;
            if (pkt_end) begin
              buf_in_commit_len <= cnt_inc;
            end
            // A transfer ending exactly on a full packet owes the host a zero-length packet.
            if (zlp_hit) begin
              zlp_pend_q <= 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          if (buf_in_commit_ack) begin
            pkt_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ep_in_writer.sv
// Bench for usb2_ep_in_writer: randomized byte streams against a packet-level
// model (expected write and commit-length queues) plus a ZLP_EN=0 instance.
module tb_usb2_ep_in_writer;

  localparam int MAX_PKT = 512;

  // clock / reset
  logic phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;
  logic reset;

  // DUT with ZLP enabled
  logic [7:0] s_data;
  logic       s_valid, s_last, s_ready;
  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic       buf_in_wren, buf_in_ready, buf_in_commit;
  logic [9:0] buf_in_commit_len;
  logic       buf_in_commit_ack, pkt_done, busy;
  logic [2:0] dbg_state;

  // DUT with ZLP disabled
  logic [7:0] s_data1;
  logic       s_valid1, s_last1, s_ready1;
  logic [8:0] buf_in_addr1;
  logic [7:0] buf_in_data1;
  logic       buf_in_wren1, buf_in_ready1, buf_in_commit1;
  logic [9:0] buf_in_commit_len1;
  logic       buf_in_commit_ack1, pkt_done1, busy1;
  logic [2:0] dbg_state1;

  usb2_ep_in_writer #(.MAX_PKT(MAX_PKT), .ZLP_EN(1'b1)) u_dut (
    .phy_clk(phy_clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
    .pkt_done(pkt_done), .busy(busy), .dbg_state(dbg_state)
  );

  usb2_ep_in_writer #(.MAX_PKT(MAX_PKT), .ZLP_EN(1'b0)) u_dut_nozlp (
    .phy_clk(phy_clk), .reset(reset),
    .s_data(s_data1), .s_valid(s_valid1), .s_last(s_last1), .s_ready(s_ready1),
    .buf_in_addr(buf_in_addr1), .buf_in_data(buf_in_data1), .buf_in_wren(buf_in_wren1),
    .buf_in_ready(buf_in_ready1), .buf_in_commit(buf_in_commit1),
    .buf_in_commit_len(buf_in_commit_len1), .buf_in_commit_ack(buf_in_commit_ack1),
    .pkt_done(pkt_done1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // scoreboard state
  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];      // {addr, data} of each expected buffer write
  logic [9:0]  exp_len_q[$];  // expected commit lengths in order
  int commits_seen = 0;
  int pkt_seen     = 0;
  int ack_delay_max = 2;
  int ack_hold      = 0;      // 0 = random 1..3 cycles
  int wr1_cnt       = 0;

  // endpoint model: acks each commit after a random delay, holds it, then drops it
  initial begin
    int d, h;
    buf_in_commit_ack = 1'b0;
    forever begin
      @(negedge phy_clk);
      if (buf_in_commit === 1'b1 && reset === 1'b0) begin
        d = $urandom_range(0, ack_delay_max);
        h = (ack_hold > 0) ? ack_hold : $urandom_range(1, 3);
        repeat (d) @(negedge phy_clk);
        buf_in_commit_ack = 1'b1;
        repeat (h) @(negedge phy_clk);
        buf_in_commit_ack = 1'b0;
      end
    end
  end

  // monitor: checks writes, commit lengths, commit/ack timing and pkt_done
  logic       prev_ack, prev_commit, prev_wren, in_commit;
  logic [9:0] latched_len, el;
  logic [16:0] ew;
  int         wr_since;
  initial begin
    prev_ack = 0; prev_commit = 0; prev_wren = 0; in_commit = 0;
    latched_len = 0; wr_since = 0;
  end

  always @(posedge phy_clk) begin
    #2;
    if (reset === 1'b1) begin
      prev_ack = 0; prev_commit = 0; prev_wren = 0; in_commit = 0; wr_since = 0;
    end else begin
      if (buf_in_wren === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stray_write got addr=%0d data=%02h required no write", buf_in_addr, buf_in_data);
        end else begin
          ew = exp_q.pop_front();
          if ({buf_in_addr, buf_in_data} !== ew) begin
            failures++;
            $display("FAIL write got addr=%0d data=%02h required addr=%0d data=%02h",
                     buf_in_addr, buf_in_data, ew[16:8], ew[7:0]);
          end
        end
        wr_since++;
      end
      if (buf_in_commit === 1'b1 && prev_commit !== 1'b1) begin
        commits_seen++;
        checks++;
        if (exp_len_q.size() == 0) begin
          failures++;
          el = buf_in_commit_len;
          $display("FAIL unexpected_commit got len=%0d required no commit", buf_in_commit_len);
        end else begin
          el = exp_len_q.pop_front();
          if (buf_in_commit_len !== el) begin
            failures++;
            $display("FAIL commit_len got %0d required %0d", buf_in_commit_len, el);
          end
        end
        checks++;
        if (wr_since != int'(el)) begin
          failures++;
          $display("FAIL writes_per_packet got %0d required %0d", wr_since, el);
        end
        checks++;
        if (prev_wren !== (el != 10'd0)) begin
          failures++;
          $display("FAIL commit_after_gap got prev_wren=%0b required %0b", prev_wren, (el != 10'd0));
        end
        latched_len = buf_in_commit_len;
        in_commit = 1'b1;
        wr_since = 0;
      end else if (in_commit) begin
        checks++;
        if (buf_in_commit_len !== latched_len) begin
          failures++;
          $display("FAIL commit_len_hold got %0d required %0d", buf_in_commit_len, latched_len);
        end
        if (buf_in_commit !== 1'b1 && buf_in_commit_ack !== 1'b1) in_commit = 1'b0;
      end
      if (buf_in_commit_ack === 1'b1 && prev_ack !== 1'b1) begin
        checks++;
        if ({pkt_done, buf_in_commit} !== 2'b10) begin
          failures++;
          $display("FAIL ack_response got pkt_done=%0b commit=%0b required pkt_done=1 commit=0",
                   pkt_done, buf_in_commit);
        end
      end else if (buf_in_commit_ack === 1'b1) begin
        checks++;
        if ({pkt_done, buf_in_commit} !== 2'b00) begin
          failures++;
          $display("FAIL commit_during_ack got pkt_done=%0b commit=%0b required 0 0",
                   pkt_done, buf_in_commit);
        end
      end else if (pkt_done === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL stray_pkt_done got 1 required 0");
      end
      if (pkt_done === 1'b1) pkt_seen++;
      prev_ack    = buf_in_commit_ack;
      prev_commit = buf_in_commit;
      prev_wren   = buf_in_wren;
    end
  end

  always @(posedge phy_clk) begin
    #2;
    if (buf_in_wren1 === 1'b1) wr1_cnt++;
  end

  // driver tasks
  task automatic send_stream(input int n, input bit with_last, input bit gaps);
    logic [7:0] d;
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(negedge phy_clk);
      end
      d = 8'($urandom_range(0, 255));
      s_data  = d;
      s_valid = 1'b1;
      s_last  = with_last && (i == n - 1);
      guard = 0;
      while (s_ready !== 1'b1 && guard < 4000) begin
        @(negedge phy_clk);
        guard++;
      end
      if (guard >= 4000) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout got no s_ready at byte %0d required s_ready=1", i);
        s_valid = 1'b0;
        s_last  = 1'b0;
        return;
      end
      exp_q.push_back({9'(i % MAX_PKT), d});
      @(negedge phy_clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // reference packetization of a whole transfer, for the ZLP_EN=1 instance
  task automatic send_transfer(input int n, input bit gaps);
    int full, rem;
    full = n / MAX_PKT;
    rem  = n % MAX_PKT;
    for (int k = 0; k < full; k++) exp_len_q.push_back(10'(MAX_PKT));
    if (rem != 0) exp_len_q.push_back(10'(rem));
    else exp_len_q.push_back(10'd0);
    send_stream(n, 1'b1, gaps);
  endtask

  function automatic int packets_for(input int n);
    return n / MAX_PKT + 1;
  endfunction

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (!(exp_len_q.size() == 0 && buf_in_commit_ack === 1'b0 && buf_in_commit === 1'b0)
           && guard < 5000) begin
      @(negedge phy_clk);
      guard++;
    end
    repeat (3) @(negedge phy_clk);
    checks++;
    if (guard >= 5000) begin
      failures++;
      $display("FAIL %s_drain_timeout got %0d commits pending required 0", name, exp_len_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_writes got %0d unwritten required 0", name, exp_q.size());
    end
    checks++;
    if (pkt_seen != commits_seen) begin
      failures++;
      $display("FAIL %s_pkt_done_count got %0d required %0d", name, pkt_seen, commits_seen);
    end
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; buf_in_ready = 1'b1;
    s_data1 = 8'h00; s_valid1 = 1'b0; s_last1 = 1'b0; buf_in_ready1 = 1'b1;
    buf_in_commit_ack1 = 1'b0;
    repeat (3) @(negedge phy_clk);
    checks++;
    if ({s_ready, buf_in_wren, buf_in_commit, pkt_done, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_controls got rdy=%0b wren=%0b commit=%0b done=%0b busy=%0b required all 0",
               s_ready, buf_in_wren, buf_in_commit, pkt_done, busy);
    end
    checks++;
    if ({buf_in_addr, buf_in_data, buf_in_commit_len} !== 27'd0) begin
      failures++;
      $display("FAIL reset_data got addr=%0d data=%02h len=%0d required 0",
               buf_in_addr, buf_in_data, buf_in_commit_len);
    end
    reset = 1'b0;
    @(negedge phy_clk);
  endtask

  task automatic test_short_packet();
    logic [7:0] vals [3];
    int guard;
    vals = '{8'hA1, 8'hA2, 8'hA3};
    exp_len_q.push_back(10'd3);
    for (int k = 0; k < 3; k++) begin
      s_data = vals[k]; s_valid = 1'b1; s_last = (k == 2);
      guard = 0;
      while (s_ready !== 1'b1 && guard < 100) begin
        @(negedge phy_clk);
        guard++;
      end
      exp_q.push_back({9'(k), vals[k]});
      @(negedge phy_clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if ({buf_in_wren, buf_in_addr, buf_in_data, buf_in_commit} !== {1'b1, 9'd2, 8'hA3, 1'b0}) begin
      failures++;
      $display("FAIL short_last_write got wren=%0b addr=%0d data=%02h commit=%0b required 1 2 a3 0",
               buf_in_wren, buf_in_addr, buf_in_data, buf_in_commit);
    end
    @(negedge phy_clk);
    checks++;
    if ({buf_in_commit, buf_in_commit_len, buf_in_wren} !== {1'b1, 10'd3, 1'b0}) begin
      failures++;
      $display("FAIL short_commit got commit=%0b len=%0d wren=%0b required 1 3 0",
               buf_in_commit, buf_in_commit_len, buf_in_wren);
    end
    wait_drain("short");
  endtask

  task automatic test_split();
    int c0;
    c0 = commits_seen;
    send_transfer(1030, 1'b1);
    wait_drain("split");
    checks++;
    if (commits_seen - c0 != 3) begin
      failures++;
      $display("FAIL split_commits got %0d required 3", commits_seen - c0);
    end
  endtask

  task automatic test_zlp();
    int c0;
    c0 = commits_seen;
    send_transfer(512, 1'b0);
    wait_drain("zlp");
    checks++;
    if (commits_seen - c0 != 2) begin
      failures++;
      $display("FAIL zlp_commits got %0d required 2", commits_seen - c0);
    end
  endtask

  task automatic test_no_zlp();
    int guard, n_commit;
    logic [9:0] last_len;
    wr1_cnt = 0; n_commit = 0; last_len = 10'h3ff;
    for (int i = 0; i < 512; i++) begin
      s_data1 = 8'(i); s_valid1 = 1'b1; s_last1 = (i == 511);
      guard = 0;
      while (s_ready1 !== 1'b1 && guard < 100) begin
        @(negedge phy_clk);
        guard++;
      end
      @(negedge phy_clk);
    end
    s_valid1 = 1'b0; s_last1 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (buf_in_commit1 === 1'b1 && buf_in_commit_ack1 === 1'b0) begin
        n_commit++;
        last_len = buf_in_commit_len1;
        buf_in_commit_ack1 = 1'b1;
      end else begin
        buf_in_commit_ack1 = 1'b0;
      end
      @(negedge phy_clk);
    end
    buf_in_commit_ack1 = 1'b0;
    checks++;
    if (n_commit != 1 || last_len !== 10'd512) begin
      failures++;
      $display("FAIL nozlp_commits got count=%0d len=%0d required count=1 len=512", n_commit, last_len);
    end
    checks++;
    if (wr1_cnt != 512) begin
      failures++;
      $display("FAIL nozlp_writes got %0d required 512", wr1_cnt);
    end
  endtask

  task automatic test_ready_stall();
    send_transfer(20, 1'b1);
    send_transfer(30, 1'b1);
    buf_in_ready = 1'b0;
    wait_drain("stall");
    s_data = 8'h55; s_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge phy_clk);
      checks++;
      if ({s_ready, buf_in_wren, busy} !== 3'b000) begin
        failures++;
        $display("FAIL stall_idle got rdy=%0b wren=%0b busy=%0b required 0 0 0", s_ready, buf_in_wren, busy);
      end
    end
    buf_in_ready = 1'b1;
    s_valid = 1'b0;
    @(negedge phy_clk);
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_resume got s_ready=%0b required 1", s_ready);
    end
    send_transfer(10, 1'b1);
    wait_drain("resume");
  endtask

  task automatic test_long_ack();
    int c0;
    c0 = commits_seen;
    ack_hold = 4; ack_delay_max = 0;
    send_transfer(700, 1'b1);
    wait_drain("long_ack");
    checks++;
    if (commits_seen - c0 != 2) begin
      failures++;
      $display("FAIL long_ack_commits got %0d required 2", commits_seen - c0);
    end
    ack_hold = 0; ack_delay_max = 2;
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = commits_seen;
    send_stream(100, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge phy_clk);
    checks++;
    if ({s_ready, buf_in_wren, buf_in_commit, pkt_done, busy, buf_in_addr, buf_in_data, buf_in_commit_len}
        !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got rdy=%0b wren=%0b commit=%0b busy=%0b addr=%0d len=%0d required all 0",
               s_ready, buf_in_wren, buf_in_commit, busy, buf_in_addr, buf_in_commit_len);
    end
    reset = 1'b0;
    repeat (10) @(negedge phy_clk);
    checks++;
    if (commits_seen != c0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_discard got commits=%0d pending_writes=%0d required commits=0 pending=0",
               commits_seen - c0, exp_q.size());
    end
    send_transfer(5, 1'b0);
    wait_drain("after_reset");
  endtask

  task automatic test_back_to_back();
    int c0, n, want;
    c0 = commits_seen; want = 0;
    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 2))
        0: n = $urandom_range(1, 16);
        1: n = $urandom_range(505, 520);
        default: n = $urandom_range(1, 1100);
      endcase
      want += packets_for(n) - ((n % MAX_PKT == 0) ? 0 : 0);
      send_transfer(n, 1'b1);
    end
    wait_drain("back_to_back");
    checks++;
    if (commits_seen - c0 != want) begin
      failures++;
      $display("FAIL back_to_back_commits got %0d required %0d", commits_seen - c0, want);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got no finish required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_short_packet();
    test_split();
    test_zlp();
    test_no_zlp();
    test_ready_stall();
    test_long_ack();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb2_ep_in_writer.md
# usb2_ep_in_writer

Client-side packetizer driving the IN half of a double-buffered USB 2.0 endpoint. It accepts a byte stream with valid/ready/last flow control and writes each byte into the endpoint's current buffer. It commits a packet when the packet is full or the stream marks its last byte, then completes the commit/ack handshake before it starts the next packet. It sits between user logic and the endpoint buffer block, in the endpoint's write-clock domain.

## Interface
- MAX_PKT, 512: max packet length in bytes; legal range 1..512.
- ZLP_EN, 1: when 1, a stream ending exactly on a MAX_PKT boundary is followed by a zero-length commit.
- phy_clk  in  1  sole clock; the endpoint's wr_clk is driven from the same net.
- reset  in  1  synchronous, active-high reset.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_last  in  1  s_data is the final byte of a transfer.
- s_ready  out  1  block accepts a byte this cycle.
- buf_in_addr  out  9  byte offset within the current endpoint buffer.
- buf_in_data  out  8  write data.
- buf_in_wren  out  1  write strobe, one cycle per byte.
- buf_in_ready  in  1  current endpoint buffer is free.
- buf_in_commit  out  1  level request to commit the current buffer.
- buf_in_commit_len  out  10  committed byte count, 0..512.
- buf_in_commit_ack  in  1  endpoint acknowledge; a multi-cycle pulse.
- pkt_done  out  1  one-cycle pulse when a commit is acknowledged.
- busy  out  1  a packet is in progress; high in any state other than IDLE.

## Operation
- The state machine has five states: IDLE, FILL, GAP, COMMIT, RELEASE.
- IDLE:
  - If buf_in_ready=1 and zlp_pend=1, load len=0, clear zlp_pend and go to GAP.
  - Otherwise, if buf_in_ready=1, clear cnt and go to FILL.
- FILL:
  - s_ready=1.
  - On accept (s_valid & s_ready), register buf_in_addr=cnt[8:0], buf_in_data=s_data and buf_in_wren=1, then cnt<=cnt+1.
  - If the accepted byte has cnt+1==MAX_PKT or s_last=1, load len=cnt+1 and go to GAP.
  - If ZLP_EN=1, s_last=1 and cnt+1==MAX_PKT, set zlp_pend.
- GAP: one cycle with no write, so the final wren precedes the commit. Then go to COMMIT.
- COMMIT:
  - Hold buf_in_commit=1 and buf_in_commit_len=len.
  - When buf_in_commit_ack=1, drop buf_in_commit, pulse pkt_done and go to RELEASE.
- RELEASE: hold buf_in_commit=0 until buf_in_commit_ack=0, then go to IDLE. This guarantees a low gap, so the endpoint's edge detector sees each commit.
- A transfer longer than MAX_PKT splits into back-to-back full packets. Only the final packet carries the remainder.
- s_last on a byte that also fills the packet ends the transfer; no extra packet is generated unless ZLP_EN applies.
- s_valid in any state other than FILL is ignored. The byte is not consumed and must be held by the source.
- cnt is 10 bits and never exceeds MAX_PKT; the address is cnt[8:0].
- buf_in_commit_len is held stable from the GAP→COMMIT edge until RELEASE exits.

## Timing
- Reset values: s_ready=0, buf_in_addr=0, buf_in_data=0, buf_in_wren=0, buf_in_commit=0, buf_in_commit_len=0, pkt_done=0, busy=0. State=IDLE, cnt=0, zlp_pend=0.
- Reset mid-packet discards the partial packet; no commit is issued. Reset during COMMIT drops buf_in_commit the next cycle.
- Write latency: a byte accepted in cycle t appears on buf_in_wren/addr/data in cycle t+1.
- The final byte accepted in cycle t gives wren at t+1 (state GAP) and buf_in_commit=1 from t+2.
- With the ack rising in cycle a: buf_in_commit=0 and pkt_done=1 in cycle a+1.
- RELEASE exits the cycle after the ack is seen low. IDLE re-samples buf_in_ready the following cycle.
- Throughput: one byte per cycle in FILL. Per-packet overhead is GAP + ack latency + RELEASE + 1 IDLE cycle.
- If buf_in_ready=0 (both buffers full), the block stays in IDLE with s_ready=0 indefinitely.

## Test plan
- Reset, then a 3-byte stream 0xA1,0xA2,0xA3 with last on 0xA3 → writes at addr 0,1,2, then commit with len=3, then pkt_done one cycle after the ack.
- MAX_PKT=512, 1030-byte stream → commits of len 512, 512, 6, with addr wrapping to 0 at each new packet.
- ZLP_EN=1, exactly 512 bytes → commit len=512 followed by commit len=0. With ZLP_EN=0, only len=512.
- Hold buf_in_ready=0 after two packets → s_ready stays 0, no wren. Raise buf_in_ready → FILL resumes on the next cycle.
- Ack held high for 4 cycles, then low → buf_in_commit low for the whole ack pulse, and the next commit rises only after the ack falls.
- Assert reset after 100 bytes of a packet → no commit, all outputs 0 the next cycle, and the next packet starts at addr 0.
